pixel_scan_writer: RTL and testbench

PIXEL_SCAN_WRITER -- requirements
Module: pixel_scan_writer

---
 rtl/pixel_scan_writer_pkg.sv | 27 ++
 rtl/pixel_fifo.sv | 45 ++++
 rtl/pixel_scan_writer.sv | 148 ++++++++++++++
 tb/tb_pixel_scan_writer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_scan_writer_pkg.sv
// Shared raymarcher types: scan FSM states, framebuffer address/pixel widths,
// the delay-line entry and the debug view of the scan writer.
package pixel_scan_writer_pkg;

  localparam int ADDR_W  = 19;
  localparam int PIX_W   = 24;
  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } scan_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } dl_entry_t;

  typedef struct packed {
    scan_state_t state;
    logic [7:0]  outstanding;
    logic [7:0]  fifo_count;
    logic        fifo_full;
  } scan_dbg_t;

endpackage

// File: rtl/pixel_fifo.sv
// Show-ahead colour FIFO; DEPTH must be a power of two. A push into a full
// FIFO is only accepted when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/pixel_scan_writer.sv
// Raster-scan pixel issuer for a fixed-latency raymarcher; colours are queued and
// written to the framebuffer. Define PIXEL_SCAN_CONTINUOUS_EN to rescan without i_start.
module pixel_scan_writer
  import pixel_scan_writer_pkg::*;
#(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PIPE_LATENCY  = 140,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  output logic [COORD_W-1:0] o_pixel_x,
  output logic [COORD_W-1:0] o_pixel_y,
  input  logic [7:0]         i_red,
  input  logic [7:0]         i_green,
  input  logic [7:0]         i_blue,
  output logic               o_wr_valid,
  input  logic               i_wr_ready,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [PIX_W-1:0]   o_wr_data,
  output logic               o_busy,
  output logic               o_frame_done,
  output scan_dbg_t          dbg
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  scan_state_t        state, next_state;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic [ADDR_W-1:0]  addr_cnt;
  logic [CNT_W-1:0]   outstanding;
  logic               issue, last_pixel, frame_end, wr_fire;
  dl_entry_t          dl [PIPE_LATENCY];
  logic [ADDR_W+PIX_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full, fifo_empty;

  assign last_pixel = (x_cnt == COORD_W'(SCREEN_WIDTH-1)) &&
                      (y_cnt == COORD_W'(SCREEN_HEIGHT-1));

  // Write channel: a beat transfers on a cycle with o_wr_valid && i_wr_ready; while
  // valid is high and ready low, addr/data hold. Valid never drops without a transfer.
  assign wr_fire = o_wr_valid && i_wr_ready;

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE:  if (i_start) next_state = SCAN;
      SCAN: begin
        // Credit rule: pixels in the delay line plus FIFO never exceed FIFO_DEPTH.
        issue = (outstanding < CNT_W'(FIFO_DEPTH));
        if (issue && last_pixel) next_state = DRAIN;
      end
      DRAIN: begin
        if (outstanding == '0 || (outstanding == CNT_W'(1) && wr_fire)) begin
          frame_end = 1'b1;
`ifdef PIXEL_SCAN_CONTINUOUS_EN
          next_state = SCAN;
`else
          next_state = IDLE;
`endif
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      o_frame_done <= 1'b0;
      o_pixel_x    <= '0;
      o_pixel_y    <= '0;
      x_cnt        <= '0;
      y_cnt        <= '0;
      addr_cnt     <= '0;
      outstanding  <= '0;
    end else begin
      state        <= next_state;
      o_frame_done <= frame_end;
      if (issue) begin
        o_pixel_x <= x_cnt;
        o_pixel_y <= y_cnt;
        if (last_pixel) begin
          x_cnt    <= '0;
          y_cnt    <= '0;
          addr_cnt <= '0;
        end else begin
          addr_cnt <= addr_cnt + 1'b1;
          if (x_cnt == COORD_W'(SCREEN_WIDTH-1)) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 1'b1;
          end else begin
            x_cnt <= x_cnt + 1'b1;
          end
        end
      end
      case ({issue, wr_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Stage k holds the pixel issued k+1 cycles ago; the last stage lines up with its colour.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LATENCY; i++) dl[i] <= '0;
    end else begin
      dl[0].valid <= issue;
      dl[0].addr  <= addr_cnt;
      for (int i = 1; i < PIPE_LATENCY; i++) dl[i] <= dl[i-1];
    end
  end

  pixel_fifo #(
    .WIDTH (ADDR_W + PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (dl[PIPE_LATENCY-1].valid),
    .wdata ({dl[PIPE_LATENCY-1].addr, i_red, i_green, i_blue}),
    .pop   (wr_fire),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign o_wr_valid = !fifo_empty;
  assign o_wr_addr  = fifo_empty ? '0 : fifo_rdata[ADDR_W+PIX_W-1 -: ADDR_W];
  assign o_wr_data  = fifo_empty ? '0 : fifo_rdata[PIX_W-1:0];
  assign o_busy     = (state != IDLE);

  always_comb begin
    dbg             = '0;
    dbg.state       = state;
    dbg.outstanding = 8'(outstanding);
    dbg.fifo_count  = 8'(fifo_count);
    dbg.fifo_full   = fifo_full;
  end

endmodule

// File: tb/tb_pixel_scan_writer.sv
// Bench for pixel_scan_writer on a small screen: a delayed colour model stands in for
// the raymarcher and a scoreboard queue holds every expected framebuffer write.
module tb_pixel_scan_writer;
  import pixel_scan_writer_pkg::*;

  localparam int W      = 16;
  localparam int H      = 8;
  localparam int L      = 6;
  localparam int DEPTH  = 16;
  localparam int N      = W * H;
  localparam int BUDGET = 4000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               i_start = 1'b0;
  logic               i_wr_ready = 1'b0;
  logic [7:0]         i_red = '0, i_green = '0, i_blue = '0;
  logic [COORD_W-1:0] o_pixel_x, o_pixel_y;
  logic               o_wr_valid, o_busy, o_frame_done;
  logic [ADDR_W-1:0]  o_wr_addr;
  logic [PIX_W-1:0]   o_wr_data;
  scan_dbg_t          dbg;

  logic [ADDR_W+PIX_W-1:0] exp_q[$];
  int n_tests = 0, n_fail = 0;
  int frame_writes = 0, done_cnt = 0, cyc = 0, last_wr_cyc = 0;
  int ready_mode = 0;
  bit sb_en = 1'b1;
  logic [2*COORD_W-1:0] hist [L];

  pixel_scan_writer #(
    .SCREEN_WIDTH  (W),
    .SCREEN_HEIGHT (H),
    .PIPE_LATENCY  (L),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_start      (i_start),
    .o_pixel_x    (o_pixel_x),
    .o_pixel_y    (o_pixel_y),
    .i_red        (i_red),
    .i_green      (i_green),
    .i_blue       (i_blue),
    .o_wr_valid   (o_wr_valid),
    .i_wr_ready   (i_wr_ready),
    .o_wr_addr    (o_wr_addr),
    .o_wr_data    (o_wr_data),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .dbg          (dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W+PIX_W-1:0] exp_pixel(input int a);
    logic [7:0] x, y;
    x = 8'(a % W);
    y = 8'(a / W);
    return {ADDR_W'(a), x, y, 8'h5A};
  endfunction

  // Raymarcher model: colour for the coordinate seen L-1 cycles earlier, i.e. L
  // cycles after the issue decision that loaded the coordinate register.
  always @(negedge clk) begin
    for (int i = L - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {o_pixel_y, o_pixel_x};
    i_red   = hist[L-1][7:0];
    i_green = hist[L-1][COORD_W+7:COORD_W];
    i_blue  = 8'h5A;
  end

  // write-ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       i_wr_ready = 1'b1;
      1:       i_wr_ready = 1'($urandom_range(0, 1));
      default: i_wr_ready = (frame_writes < 3);
    endcase
  end

  // scoreboard monitor
  always @(negedge clk) begin
    logic [63:0] exp_w;
    cyc++;
    if (sb_en && o_wr_valid && i_wr_ready) begin
      frame_writes++;
      last_wr_cyc = cyc;
      if (exp_q.size() > 0) exp_w = 64'(exp_q.pop_front());
      else                  exp_w = 64'h1 << (ADDR_W + PIX_W);
      check_eq("wr", 64'({o_wr_addr, o_wr_data}), exp_w);
    end
    if (sb_en && o_frame_done) begin
      done_cnt++;
      check_eq("done_lat", 64'(cyc - last_wr_cyc), 64'(1));
      check_eq("done_q_empty", 64'(exp_q.size()), 64'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    for (int a = 0; a < N; a++) exp_q.push_back(exp_pixel(a));
    frame_writes = 0;
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start_cnt = done_cnt;
    int n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(done_cnt != start_cnt), 64'(1));
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int n = 0;
    while (frame_writes < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(frame_writes >= target), 64'(1));
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_px",    64'(o_pixel_x),       64'(0));
    check_eq("rst_py",    64'(o_pixel_y),       64'(0));
    check_eq("rst_valid", 64'(o_wr_valid),      64'(0));
    check_eq("rst_addr",  64'(o_wr_addr),       64'(0));
    check_eq("rst_data",  64'(o_wr_data),       64'(0));
    check_eq("rst_busy",  64'(o_busy),          64'(0));
    check_eq("rst_done",  64'(o_frame_done),    64'(0));
    check_eq("rst_state", 64'(dbg.state),       64'(IDLE));
    check_eq("rst_outst", 64'(dbg.outstanding), 64'(0));
    check_eq("rst_fifo",  64'(dbg.fifo_count),  64'(0));
  endtask

  initial begin
    int quiet;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    tick();
    reset = 1'b0;

`ifdef PIXEL_SCAN_CONTINUOUS_EN
    ready_mode = 0;
    start_frame();
    wait_done("cont_f1_done", BUDGET);
    for (int a = 0; a < N; a++) exp_q.push_back(exp_pixel(a));
    frame_writes = 0;
    wait_done("cont_f2_done", BUDGET);
    check_eq("cont_f2_writes", 64'(frame_writes), 64'(N));
    check_eq("cont_busy",      64'(o_busy),       64'(1));
    check_eq("cont_state",     64'(dbg.state),    64'(SCAN));
    sb_en = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
`else
    // full frame, always ready
    ready_mode = 0;
    start_frame();
    wait_done("a_done", BUDGET);
    check_eq("a_writes", 64'(frame_writes), 64'(N));
    check_eq("a_busy",   64'(o_busy),       64'(0));

    // back-pressure from the fourth write onward
    ready_mode = 2;
    start_frame();
    wait_writes("b_first3", 3, 200);
    repeat (500) @(negedge clk);
    check_eq("b_writes",   64'(frame_writes),    64'(3));
    check_eq("b_outst",    64'(dbg.outstanding), 64'(DEPTH));
    check_eq("b_full",     64'(dbg.fifo_full),   64'(1));
    check_eq("b_count",    64'(dbg.fifo_count),  64'(DEPTH));
    check_eq("b_px",       64'(o_pixel_x),       64'((3 + DEPTH - 1) % W));
    check_eq("b_py",       64'(o_pixel_y),       64'((3 + DEPTH - 1) / W));
    check_eq("b_valid",    64'(o_wr_valid),      64'(1));
    check_eq("b_state",    64'(dbg.state),       64'(SCAN));
    tick();
    ready_mode = 0;
    wait_done("b_done", BUDGET);
    check_eq("b_total", 64'(frame_writes), 64'(N));

    // random ready
    ready_mode = 1;
    start_frame();
    wait_done("c_done", BUDGET);
    check_eq("c_writes", 64'(frame_writes), 64'(N));
    ready_mode = 0;

    // reset mid-frame
    start_frame();
    wait_writes("d_reach40", 40, BUDGET);
    tick();
    sb_en = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    quiet = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_wr_valid || o_frame_done || o_busy) quiet++;
    end
    check_eq("d_quiet", 64'(quiet), 64'(0));
    exp_q.delete();
    sb_en = 1'b1;
    start_frame();
    wait_done("d_done", BUDGET);
    check_eq("d_writes", 64'(frame_writes), 64'(N));

    // i_start during SCAN is ignored
    start_frame();
    repeat (10) tick();
    check_eq("e_busy", 64'(o_busy), 64'(1));
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done("e_done", BUDGET);
    check_eq("e_writes", 64'(frame_writes), 64'(N));
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_wr_valid || o_busy) quiet++;
    end
    check_eq("e_no_rescan", 64'(quiet), 64'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
